// File: rtl/sort4_batch_ctrl_if.sv
// sort4_batch_ctrl_if: entry stream in/out handshake bundle for sort4_batch_ctrl
interface sort4_batch_ctrl_if #(parameter int DSIZE = 18);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out_data;
  logic             out_last;
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/sort4_batch_ctrl.sv
// sort4_batch_ctrl: batches up to 4 entries through a shared external sort network; SORT4_CTRL_STAT_EN adds batch_cnt
module sort4_batch_ctrl #(
  parameter int DSIZE = 18
) (
  input  logic             clk,
  input  logic             rst,
  sort4_batch_ctrl_if.slave bus,
  output logic [DSIZE-1:0] srt_a0,
  output logic [DSIZE-1:0] srt_a1,
  output logic [DSIZE-1:0] srt_a2,
  output logic [DSIZE-1:0] srt_a3,
  input  logic [DSIZE-1:0] srt_s0,
  input  logic [DSIZE-1:0] srt_s1,
  input  logic [DSIZE-1:0] srt_s2,
  input  logic [DSIZE-1:0] srt_s3,
`ifdef SORT4_CTRL_STAT_EN
  output logic [15:0]      batch_cnt,
`endif
  output logic             busy
);
  localparam logic [DSIZE-1:0] PAD = {DSIZE{1'b1}};
  typedef enum logic [1:0] {FILL, SORT, DRAIN} state_t;
  state_t state, state_nx;
  logic [DSIZE-1:0] slot [4];
  logic [DSIZE-1:0] res [4];
  logic [2:0] cnt, idx, n;
  logic last_f, alive, in_fire, out_fire, close, done;
  assign srt_a0 = slot[0];
  assign srt_a1 = slot[1];
  assign srt_a2 = slot[2];
  assign srt_a3 = slot[3];
  assign bus.out_data = res[idx[1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FILL;
    else state <= state_nx;
  // alive keeps in_ready low until the first edge after reset release
  always_comb begin
    bus.in_ready = alive && state == FILL;
    bus.out_valid = state == DRAIN;
    bus.out_last = state == DRAIN && idx == n - 3'd1 && last_f;
    busy = state != FILL;
    in_fire = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    close = in_fire && (cnt == 3'd3 || bus.in_last);
    done = out_fire && idx == n - 3'd1;
    state_nx = state == FILL ? (close ? SORT : FILL) :
               state == SORT ? DRAIN : (done ? FILL : DRAIN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        slot[i] <= PAD;
        res[i] <= '0;
      end
      cnt <= '0;
      idx <= '0;
      n <= '0;
      last_f <= 1'b0;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (in_fire) begin
        slot[cnt[1:0]] <= bus.in_data;
        cnt <= cnt + 3'd1;
      end
      if (close) begin
        n <= cnt + 3'd1;
        last_f <= bus.in_last;
      end
      if (state == SORT) begin
        res[0] <= srt_s0;
        res[1] <= srt_s1;
        res[2] <= srt_s2;
        res[3] <= srt_s3;
        idx <= '0;
      end
      if (done) begin
        for (int i = 0; i < 4; i++) slot[i] <= PAD;
        cnt <= '0;
      end else if (out_fire) idx <= idx + 3'd1;
    end
`ifdef SORT4_CTRL_STAT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) batch_cnt <= '0;
    else if (done) batch_cnt <= batch_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_sort4_batch_ctrl.sv
// tb_sort4_batch_ctrl: table-driven batches with a scoreboard plus reset/backpressure/latency sequences
module tb_sort4_batch_ctrl;
  localparam int DSIZE = 18;
  localparam int OFFSET = 8;
  localparam logic [DSIZE-1:0] PAD = {DSIZE{1'b1}};
  typedef struct {
    logic [DSIZE-1:0] din;
    logic             dl;
    logic [DSIZE-1:0] dout;
    logic             ol;
  } vec_t;
  typedef struct {
    logic [DSIZE-1:0] d;
    logic             l;
  } exp_t;
  logic clk, rst;
  logic [DSIZE-1:0] srt_a0, srt_a1, srt_a2, srt_a3, srt_s0, srt_s1, srt_s2, srt_s3;
  logic busy;
`ifdef SORT4_CTRL_STAT_EN
  logic [15:0] batch_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  vec_t vt[11];
  sort4_batch_ctrl_if #(.DSIZE(DSIZE)) bus ();
  sort4_batch_ctrl #(.DSIZE(DSIZE)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .srt_a0(srt_a0), .srt_a1(srt_a1), .srt_a2(srt_a2), .srt_a3(srt_a3),
    .srt_s0(srt_s0), .srt_s1(srt_s1), .srt_s2(srt_s2), .srt_s3(srt_s3),
`ifdef SORT4_CTRL_STAT_EN
    .batch_cnt(batch_cnt),
`endif
    .busy(busy)
  );
  // stand-in for the external bitonic network: ascending by key
  function automatic logic [4*DSIZE-1:0] sort_net(input logic [DSIZE-1:0] a0, a1, a2, a3);
    logic [DSIZE-1:0] v [4];
    logic [DSIZE-1:0] t;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (v[j][DSIZE-1:OFFSET] > v[j+1][DSIZE-1:OFFSET]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return {v[3], v[2], v[1], v[0]};
  endfunction
  assign {srt_s3, srt_s2, srt_s1, srt_s0} = sort_net(srt_a0, srt_a1, srt_a2, srt_a3);
  function automatic logic [DSIZE-1:0] e(input int k, input int s);
    return {k[9:0], s[7:0]};
  endfunction
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %h with nothing expected", bus.out_data);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(x.d));
        chk("out_last", 32'(bus.out_last), 32'(x.l));
      end
    end
  task automatic drive(input logic [DSIZE-1:0] din, input logic dl, input logic [DSIZE-1:0] dout, input logic ol);
    logic ok;
    sb.push_back('{dout, ol});
    bus.in_valid = 1'b1;
    bus.in_data = din;
    bus.in_last = dl;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL in_handshake: got no in_ready expected handshake for %h", din);
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      ok = sb.size() == 0 && !busy;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_out(input logic need_last);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.out_valid && (!need_last || bus.out_last);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL out_timeout: got no out_valid expected one");
    end
  endtask
  initial begin
    vt[0]  = '{e(5, 8'h0A), 1'b0, e(1, 8'h0D), 1'b0};
    vt[1]  = '{e(2, 8'h0B), 1'b0, e(2, 8'h0B), 1'b0};
    vt[2]  = '{e(9, 8'h0C), 1'b0, e(5, 8'h0A), 1'b0};
    vt[3]  = '{e(1, 8'h0D), 1'b1, e(9, 8'h0C), 1'b1};
    vt[4]  = '{e(7, 8'h01), 1'b0, e(3, 8'h02), 1'b0};
    vt[5]  = '{e(3, 8'h02), 1'b1, e(7, 8'h01), 1'b1};
    vt[6]  = '{e(4, 8'h44), 1'b0, e(0, 8'h10), 1'b0};
    vt[7]  = '{e(4, 8'h44), 1'b0, e(4, 8'h44), 1'b0};
    vt[8]  = '{e(0, 8'h10), 1'b0, e(4, 8'h44), 1'b0};
    vt[9]  = '{e(8, 8'h11), 1'b0, e(8, 8'h11), 1'b0};
    vt[10] = '{e(6, 8'h20), 1'b1, e(6, 8'h20), 1'b1};
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_srt_a0", 32'(srt_a0), 32'(PAD));
    chk("rst_srt_a3", 32'(srt_a3), 32'(PAD));
    @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("rel_in_ready_before_edge", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 chk("rel_in_ready_after_edge", 32'(bus.in_ready), 1);
`ifdef SORT4_CTRL_STAT_EN
    chk("stat_reset", 32'(batch_cnt), 0);
`endif
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].din, vt[i].dl, vt[i].dout, vt[i].ol);
      if (i == 3) begin
        @(negedge clk);
        chk("lat_sort_out_valid", 32'(bus.out_valid), 0);
        chk("lat_sort_busy", 32'(busy), 1);
        chk("lat_sort_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        chk("lat_drain_out_valid", 32'(bus.out_valid), 1);
        @(posedge clk);
        #1;
      end
      if (i == 5) begin
        chk("part_srt_a0", 32'(srt_a0), 32'(e(7, 8'h01)));
        chk("part_srt_a1", 32'(srt_a1), 32'(e(3, 8'h02)));
        chk("part_srt_a2", 32'(srt_a2), 32'(PAD));
        chk("part_srt_a3", 32'(srt_a3), 32'(PAD));
        wait_out(1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("part_in_ready_back", 32'(bus.in_ready), 1);
        chk("part_out_valid_off", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
`ifdef SORT4_CTRL_STAT_EN
    chk("stat_four_batches", 32'(batch_cnt), 4);
`endif
    bus.out_ready = 1'b0;
    drive(e(12, 8'h30), 1'b0, e(10, 8'h31), 1'b0);
    drive(e(10, 8'h31), 1'b0, e(11, 8'h32), 1'b0);
    drive(e(11, 8'h32), 1'b1, e(12, 8'h30), 1'b1);
    wait_out(1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_out_data", 32'(bus.out_data), 32'(e(10, 8'h31)));
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      bus.in_valid = k[0];
      bus.in_data = e(15, k);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    drive(e(20, 8'h40), 1'b0, e(20, 8'h40), 1'b0);
    drive(e(21, 8'h41), 1'b0, e(21, 8'h41), 1'b0);
    drive(e(22, 8'h42), 1'b0, e(22, 8'h42), 1'b0);
    drive(e(23, 8'h43), 1'b1, e(23, 8'h43), 1'b1);
    wait_out(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_out_data", 32'(bus.out_data), 0);
    chk("arst_srt_a0", 32'(srt_a0), 32'(PAD));
`ifdef SORT4_CTRL_STAT_EN
    chk("stat_arst", 32'(batch_cnt), 0);
`endif
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk("arst_rel_in_ready", 32'(bus.in_ready), 1);
    drive(e(3, 8'h50), 1'b0, e(1, 8'h51), 1'b0);
    drive(e(1, 8'h51), 1'b1, e(3, 8'h50), 1'b1);
    wait_idle();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sort4_batch_ctrl.md
Name: sort4_batch_ctrl

Overview:
Sequencer that shares one combinational 4-input bitonic sort network (ascending; sort0 = smallest key) across a serial stream of frequency/symbol entries in the Huffman coder.
- Collects up to 4 entries over a valid/ready input, pads unused lanes, presents the batch to the sorter, captures the result and streams it out serially in ascending key order.
- Sits between the frequency-table reader and the tree-build stage.

Parameters:
DSIZE, 18, entry width; entry = {key, symbol}.
OFFSET, 8, symbol field width; key = bits [DSIZE-1:OFFSET], compared by the sorter.
PAD, all ones (DSIZE bits), filler for unused lanes; sorts after any legal entry.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  input entry valid.
in_ready  out  1  block can accept an entry.
in_data  in  DSIZE  input entry.
in_last  in  1  entry closes the current batch (may close a batch of 1-4).
out_valid  out  1  sorted entry valid.
out_ready  in  1  downstream accepts.
out_data  out  DSIZE  sorted entry.
out_last  out  1  final entry of a batch that was closed by in_last.
srt_a0..srt_a3  out  DSIZE each  lanes driven to the external sort network (registered).
srt_s0..srt_s3  in  DSIZE each  sort network outputs, ascending.
busy  out  1  high in SORT or DRAIN.

Behaviour:
- Reset: state=FILL; cnt=0; slots 0-3 = PAD; results = 0; n=0; last_f=0.
  - Outputs during reset: in_ready=0, out_valid=0, out_last=0, busy=0, srt_a* = PAD, out_data = 0.
  - in_ready=1 from the first clock edge after reset deasserts.
- Reset asserted mid-operation: immediate return to reset state; partial batch and undrained results are discarded.
- srt_aK = slot[K] at all times (direct from registers).
- FILL (in_ready=1, out_valid=0):
  - On handshake: slot[cnt] <= in_data; cnt++.
  - If cnt==3 or in_last: n <= cnt+1; last_f <= in_last; next state SORT.
- SORT: one cycle, in_ready=0. The sorter settles from the registered slots. At the end of the cycle, res[0..3] <= srt_s0..srt_s3; idx <= 0; next state DRAIN.
- DRAIN (in_ready=0):
  - out_valid=1; out_data=res[idx]; out_last=(idx==n-1)&&last_f.
  - On handshake with idx==n-1: slots <= PAD, cnt <= 0, next state FILL. Otherwise idx++.
  - out_ready low holds out_data/out_last stable. Lanes idx>=n are pads and are never emitted.
- Latency: last input handshake at edge T -> out_valid high in cycle T+2 (after SORT).
- Throughput: a batch of n entries costs n+1+n cycles; no overlap of FILL with DRAIN.
- Boundaries:
  - in_last on the first entry gives n=1; one entry is emitted.
  - in_valid while in_ready=0 is ignored and must be held by the source.
  - Entries with key all-ones are illegal; pad ordering is undefined for them.
  - Equal keys may emerge in either order.
  - cnt, idx and n are 3 bits max; cnt never exceeds 3 in FILL.

Optional Feature:
SORT4_CTRL_STAT_EN
- Defined: adds output batch_cnt (16 bits), reset to 0. It increments on the final DRAIN handshake of each batch and wraps 0xFFFF->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Full batch: keys 5,2,9,1 (syms 0x0A,0x0B,0x0C,0x0D), in_last on the 4th -> out keys 1,2,5,9 with syms 0x0D,0x0B,0x0A,0x0C; out_last only on key 9; out_valid rises 2 cycles after the 4th handshake.
- Partial batch: keys 7,3 with in_last on the 2nd -> srt_a2/a3 = PAD; exactly two outputs (3,7); out_last on 7; in_ready returns 1 the cycle after the 7 handshake.
- Batch without in_last, then single-entry batch: keys 4,4,0,8 without in_last -> out 0,4,4,8 with out_last never set. Next, single key 6 with in_last -> one output 6 with out_last=1.
- Backpressure: out_ready low for 5 cycles during DRAIN -> out_data constant; in_valid pulses ignored (in_ready=0); no entry lost or duplicated.
- Async reset: assert rst in DRAIN mid-batch -> out_valid, busy and in_ready drop the same cycle without a clock edge; after release, a fresh batch 3,1 -> out 1,3.
- (SORT4_CTRL_STAT_EN defined) three completed batches -> batch_cnt=3; preload 0xFFFF then one batch -> batch_cnt=0.
